frame_capture_ctrl: RTL and testbench

FRAME_CAPTURE_CTRL -- requirements
Module: frame_capture_ctrl

---
 rtl/vga_cap_pkg.sv | 19 +
 rtl/capture_fifo.sv | 54 +++++
 rtl/frame_capture_ctrl.sv | 167 ++++++++++++++++
 tb/tb_frame_capture_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_cap_pkg.sv
// Shared types and default sizing for the VGA frame capture path.
// Default frame is 800x600 visible pixels into an 8-bit frame store.
package vga_cap_pkg;

    localparam int PIX_W_DEF        = 8;
    localparam int ADDR_W_DEF       = 19;
    localparam int FRAME_PIXELS_DEF = 480000;
    localparam int FIFO_DEPTH_DEF   = 4;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        SYNC,
        CAPTURE,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/capture_fifo.sv
// Synchronous show-ahead write buffer with occupancy count and flush.
// A push on a full buffer is accepted only if a pop frees a slot that cycle.
module capture_fifo #(
    parameter int W     = 27,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  buf_q [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign dout    = buf_q[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !flush) buf_q[wr_ptr] <= din;
    end

endmodule

// File: rtl/frame_capture_ctrl.sv
// Captures one VGA frame into single-port memory, sharing the port with host reads.
// CAPTURE_DECIMATE_EN keeps only even-row/even-column pixels (quarter image).
module frame_capture_ctrl
    import vga_cap_pkg::*;
#(
    parameter int PIX_W        = PIX_W_DEF,
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int FRAME_PIXELS = FRAME_PIXELS_DEF,
    parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              vsync,
    input  logic              visible,
    input  logic [PIX_W-1:0]  pixel_in,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [PIX_W-1:0]  mem_wdata,
    input  logic [PIX_W-1:0]  mem_rdata,
    input  logic              host_req,
    input  logic [ADDR_W-1:0] host_addr,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [PIX_W-1:0]  host_rdata,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic              frame_err
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = ADDR_W + PIX_W;
`ifdef CAPTURE_DECIMATE_EN
    localparam int END_CNT = FRAME_PIXELS / 4;
`else
    localparam int END_CNT = FRAME_PIXELS;
`endif

    state_t            state;
    state_t            state_n;
    logic [ADDR_W-1:0] wr_addr;
    logic [EW-1:0]     head;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;
    logic              arm;
    logic              push;
    logic              last_px;
    logic              err_evt;
    logic              drop;
    logic              wr_go;
    logic              host_go;
    logic              dec_ok;

`ifdef CAPTURE_DECIMATE_EN
    logic col_par;
    logic row_par;
    logic vis_d;

    // Parities restart each frame; a falling visible edge ends a line.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col_par <= 1'b0;
            row_par <= 1'b0;
            vis_d   <= 1'b0;
        end else if (state != CAPTURE) begin
            col_par <= 1'b0;
            row_par <= 1'b0;
            vis_d   <= 1'b0;
        end else begin
            vis_d <= visible;
            if (visible) begin
                col_par <= ~col_par;
            end else if (vis_d) begin
                col_par <= 1'b0;
                row_par <= ~row_par;
            end
        end
    end

    assign dec_ok = !col_par && !row_par;
`else
    assign dec_ok = 1'b1;
`endif

    assign arm     = start && !abort && (state == IDLE || state == DONE);
    assign push    = state == CAPTURE && visible && dec_ok && !abort;
    assign last_px = push && wr_addr == ADDR_W'(END_CNT - 1);
    assign err_evt = state == CAPTURE && !vsync && !last_px && !abort;
    assign drop    = push && full && !wr_go;

    // Writes yield to the host until the buffer is half full.
    assign wr_go   = !reset && !abort && !empty &&
                     (!host_req || count >= CW'(FIFO_DEPTH / 2));
    assign host_go = !reset && host_req && !wr_go;

    capture_fifo #(
        .W     (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .flush (abort),
        .push  (push),
        .pop   (wr_go),
        .din   ({wr_addr, pixel_in}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_comb begin
        state_n = state;
        if (abort) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE, DONE: if (start)              state_n = ARMED;
                ARMED:      if (!vsync)             state_n = SYNC;
                SYNC:       if (vsync)              state_n = CAPTURE;
                CAPTURE:    if (last_px || !vsync)  state_n = DRAIN;
                DRAIN:      if (empty)              state_n = DONE;
                default:                            state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_addr     <= '0;
            overflow    <= 1'b0;
            frame_err   <= 1'b0;
            host_rvalid <= 1'b0;
        end else begin
            host_rvalid <= host_go;
            if (arm) begin
                wr_addr   <= '0;
                overflow  <= 1'b0;
                frame_err <= 1'b0;
            end else begin
                if (push)    wr_addr   <= wr_addr + 1'b1;
                if (drop)    overflow  <= 1'b1;
                if (err_evt) frame_err <= 1'b1;
            end
        end
    end

    assign busy       = state inside {ARMED, SYNC, CAPTURE, DRAIN};
    assign done       = state == DONE;
    assign mem_en     = wr_go || host_go;
    assign mem_we     = wr_go;
    assign mem_addr   = wr_go   ? head[EW-1:PIX_W] :
                        host_go ? host_addr : '0;
    assign mem_wdata  = wr_go ? head[PIX_W-1:0] : '0;
    assign host_gnt   = host_go;
    assign host_rdata = host_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Directed bench for frame_capture_ctrl on a reduced frame size.
// Expected memory writes are queued at stimulus time and retired by a monitor.
module tb_frame_capture_ctrl;

    localparam int PW = 8;
    localparam int AW = 10;
    localparam int FD = 4;
`ifdef CAPTURE_DECIMATE_EN
    localparam int LW = 12, NR = 8, FP = 96, LPR = 6, EXP_W = FP / 4;
`else
    localparam int LW = 6, NR = 4, FP = 24, LPR = 3, EXP_W = FP;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          vsync = 1'b1;
    logic          visible = 1'b0;
    logic [PW-1:0] pixel_in = '0;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [PW-1:0] mem_wdata;
    logic [PW-1:0] mem_rdata;
    logic          host_req = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic          host_gnt, host_rvalid;
    logic [PW-1:0] host_rdata;
    logic          busy, done, overflow, frame_err;

    always #5 clock = ~clock;

    frame_capture_ctrl #(
        .PIX_W(PW), .ADDR_W(AW), .FRAME_PIXELS(FP), .FIFO_DEPTH(FD)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .vsync(vsync), .visible(visible), .pixel_in(pixel_in),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .host_req(host_req), .host_addr(host_addr), .host_gnt(host_gnt),
        .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .busy(busy), .done(done), .overflow(overflow), .frame_err(frame_err)
    );

    logic [PW-1:0] bmem [1024];

    always @(posedge clock) begin
        if (mem_en && mem_we)  bmem[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= bmem[mem_addr];
    end

    int checks = 0;
    int fails = 0;
    int wr_cnt = 0;
    int base, addr, occ, drops, mpush;
    bit blocked = 1'b0;
    logic [AW+PW-1:0] sb [$];
    logic gnt_d = 1'b0;
    logic [AW-1:0] raddr_d = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        logic [AW+PW-1:0] e;
        if (reset) begin
            gnt_d = 1'b0;
        end else begin
            chk("rvalid", host_rvalid, gnt_d);
            if (gnt_d) chk("rdata", host_rdata, bmem[raddr_d]);
            if (mem_en && mem_we) begin
                wr_cnt++;
                chk("wr_pending", sb.size() > 0, 1'b1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("wr_addr_data", {mem_addr, mem_wdata}, e);
                end
            end
            if (host_gnt) chk("gnt_rd", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, host_addr});
            gnt_d = host_gnt;
            raddr_d = host_addr;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic bit want(input int r, input int c);
`ifdef CAPTURE_DECIMATE_EN
        return (r % 2 == 0) && (c % 2 == 0);
`else
        return (r >= 0) && (c >= 0);
`endif
    endfunction

    task automatic px(input int r, input int c);
        logic [PW-1:0] d;
        d = PW'(r * 37 + c * 5 + 11);
        visible = 1'b1;
        pixel_in = d;
        if (want(r, c)) begin
            if (blocked && occ == FD) begin
                drops++;
            end else begin
                sb.push_back({AW'(addr), d});
                if (blocked) occ++;
            end
            addr++;
            mpush++;
        end
        tick();
    endtask

    task automatic line(input int r, input int n);
        for (int c = 0; c < n; c++) px(r, c);
        visible = 1'b0;
        repeat (3) tick();
    endtask

    task automatic begin_frame();
        addr = 0; occ = 0; drops = 0; mpush = 0;
        base = wr_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("armed", {busy, done, overflow, frame_err}, 4'b1000);
        vsync = 1'b0;
        repeat (2) tick();
        vsync = 1'b1;
        repeat (2) tick();
    endtask

    task automatic wait_done();
        for (int i = 0; i < 80 && !done; i++) tick();
        chk("done", done, 1'b1);
    endtask

    task automatic host_read(input logic [AW-1:0] a);
        host_req = 1'b1;
        host_addr = a;
        #1;
        chk("host_gnt", host_gnt, 1'b1);
        tick();
        host_req = 1'b0;
        chk("host_rd", {host_rvalid, host_rdata}, {1'b1, bmem[a]});
    endtask

    initial begin
        int rem, rr;
        for (int i = 0; i < 1024; i++) bmem[i] <= PW'(i * 7 + 3);
        #2;
        chk("rst_flags", {busy, done, overflow, frame_err, host_gnt, host_rvalid}, 6'b0);
        chk("rst_mem", {mem_en, mem_we, mem_addr, mem_wdata, host_rdata}, '0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        tick();
        chk("idle", {busy, done}, 2'b00);
        host_read(7);

        // Clean frame, no host traffic.
        begin_frame();
        for (int r = 0; r < NR; r++) line(r, LW);
        wait_done();
        chk("clean_writes", wr_cnt - base, EXP_W);
        chk("clean_flags", {overflow, frame_err}, 2'b00);
        chk("clean_sb", sb.size(), 0);

        // Host request held through the frame.
        host_req = 1'b1;
        host_addr = 100;
        begin_frame();
        for (int r = 0; r < NR; r++) line(r, LW);
        host_req = 1'b0;
        wait_done();
        chk("host_writes", wr_cnt - base, EXP_W);
        chk("host_ovf", overflow, 1'b0);
        chk("host_sb", sb.size(), 0);

        // Early vsync after 10 visible pixels.
        begin_frame();
        rem = 10;
        rr = 0;
        while (rem > 0) begin
            line(rr, (rem < LW) ? rem : LW);
            rem -= (rem < LW) ? rem : LW;
            rr++;
        end
        vsync = 1'b0;
        tick();
        vsync = 1'b1;
        wait_done();
        chk("err_flag", frame_err, 1'b1);
        chk("err_writes", wr_cnt - base, mpush);
        chk("err_sb", sb.size(), 0);

        // Write path blocked: 5th push dropped, then push on full with pop.
        begin_frame();
        force dut.wr_go = 1'b0;
        blocked = 1'b1;
        for (int c = 0; c < LW; c++) begin
            if (blocked && mpush == 5) begin
                release dut.wr_go;
                blocked = 1'b0;
            end
            px(0, c);
            if (blocked) chk("ovf_step", overflow, drops > 0);
        end
        visible = 1'b0;
        repeat (3) tick();
        for (int r = 1; r < NR; r++) line(r, LW);
        wait_done();
        chk("ovf_flag", overflow, 1'b1);
        chk("ovf_writes", wr_cnt - base, EXP_W - 1);
        chk("ovf_sb", sb.size(), 0);

        // Abort with three entries buffered.
        begin_frame();
        force dut.wr_go = 1'b0;
        blocked = 1'b1;
        for (int c = 0; c < LW && mpush < 3; c++) px(0, c);
        visible = 1'b0;
        abort = 1'b1;
        release dut.wr_go;
        blocked = 1'b0;
        sb.delete();
        #1;
        chk("abort_we", mem_we, 1'b0);
        tick();
        abort = 1'b0;
        chk("abort_idle", {busy, done, overflow, frame_err}, 4'b0);
        repeat (4) tick();
        chk("abort_busy", busy, 1'b0);

        // Reset while stuck in DRAIN.
        begin_frame();
        for (int r = 0; r < LPR; r++) line(r, LW);
        force dut.wr_go = 1'b0;
        blocked = 1'b1;
        line(LPR, LW);
        chk("drain_busy", {busy, done, overflow}, 3'b101);
        host_req = 1'b1;
        host_addr = 5;
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_flags", {busy, done, overflow, frame_err, host_gnt, host_rvalid}, 6'b0);
        chk("rst_mid_mem", {mem_en, mem_we, mem_addr, mem_wdata, host_rdata}, '0);
        sb.delete();
        release dut.wr_go;
        blocked = 1'b0;
        tick();
        reset = 1'b0;
        chk("post_rst_rv", host_rvalid, 1'b0);
        host_read(5);
        repeat (3) tick();

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
